rgbw_pwm_gen: RTL and testbench
===============================

RGBW_PWM_GEN -- requirements
Module: rgbw_pwm_gen

Interface
REQ-001 Parameter PRESC, default 1: PWM counter advances once every PRESC clk cycles (legal 1..255).
REQ-002 Parameter STAGGER, default 1: 1 gives each channel its own phase offset; 0 keeps all channels in phase.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 duty_ld  input  1  one-cycle strobe; duty0..duty3 valid in that cycle.
REQ-006 duty0..duty3  input  8 each  requested duty for red, green, blue, white.
REQ-007 d0..d3  output  1 each  registered PWM outputs for red, green, blue, white.
REQ-008 period_end  output  1  one-cycle pulse when the counter wraps.
REQ-009 upd_ack  output  1  one-cycle pulse when pending duties are applied.
REQ-010 pend  output  1  high while captured duties wait for the next period boundary.

Function
REQ-011 Prescaler: the counter runs 0..PRESC-1 on every clk; tick is high in the cycle where it equals PRESC-1, then it returns to 0; PRESC=1 gives tick on every cycle.
REQ-012 Main counter cnt: 8-bit; increments on tick; wraps 255->0; period = 256 ticks.
REQ-013 Boundary: the cycle where tick=1 and cnt=255; period_end=1 on the following cycle only.
REQ-014 Capture: duty_ld=1 loads duty0..3 into the pending registers and sets pend on the next edge; a later duty_ld before the boundary overwrites pending (last write wins).
REQ-015 Apply: at the boundary, if pend=1, active <= pending, pend clears, and upd_ack pulses on the next cycle; if pend=0, active is unchanged and there is no upd_ack.
REQ-016 Simultaneous duty_ld and boundary: active takes the old pending contents (if pend=1); the new values go to pending; pend ends set.
REQ-017 Active registers change only at the boundary; no mid-period glitch.
REQ-018 Channel phase: with STAGGER=1, ph_k = (cnt + 64*k) mod 256 for k=0..3; with STAGGER=0, ph_k = cnt.
REQ-019 Compare: d_k <= (ph_k < active_k), unsigned 8-bit, registered; d_k lags cnt by 1 clk.
REQ-020 duty 0 gives d_k constantly 0; duty 255 gives 255 high ticks per 256; duty N gives exactly N high ticks per period.
REQ-021 Between ticks, all outputs hold their values.

Reset
REQ-022 When reset=1 at a clk edge: prescaler=0, cnt=0, pending=0, active=0, pend=0, d0..d3=0, period_end=0, upd_ack=0.
REQ-023 Reset has priority over duty_ld and tick; a capture that is in flight is discarded.
REQ-024 After release, the first tick occurs PRESC cycles later, and cnt starts from 0.

Verification
REQ-025 PRESC=1, STAGGER=0, duty_ld with duties 64/128/192/255 -> after the first boundary and for every full period, d0..d3 show high counts 64/128/192/255 per 256 clk; upd_ack pulses once.
REQ-026 PRESC=1, STAGGER=1, all duties 64 -> each d_k is high for 64 cycles; the rising edges of d1, d2, d3 come 64, 128, 192 ticks before d0 rises (d_k rises when cnt = 256-64*k mod 256).
REQ-027 duty_ld=10 at cnt=20, then duty_ld=200 at cnt=100 -> active is unchanged until the boundary, then 200; one upd_ack.
REQ-028 duty_ld=50 in the exact boundary cycle while pending=30 with pend=1 -> the next period uses 30, the following period uses 50, and pend stays high through the first period.
REQ-029 reset=1 asserted at cnt=130 with pend=1 -> the next cycle shows all outputs 0 and pend=0; the period after release has all d_k=0 until a new duty_ld is applied.
REQ-030 PRESC=3, duty 1 -> d_k is high for exactly 3 clk per 768-clk period; period_end spacing is 768 clk.

Source files
------------

// File: rtl/rgbw_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rgbw_pwm_gen
//  Description : Four-channel (red, green, blue, white) 8-bit PWM generator.
//                A prescaler divides clk by PRESC to form a tick; an 8-bit
//                counter advances on every tick and defines a 256-tick PWM
//                period. New duty values are captured into pending
//                registers and only take effect at the next period boundary,
//                so a running period is never disturbed. With STAGGER=1 each
//                channel runs 64 counts out of phase from its neighbour,
//                spreading the switching edges over the period.
//
//  Ports       : clk         system clock, all state on the rising edge
//                reset       synchronous active-high reset
//                duty_ld     one-cycle strobe qualifying duty0..duty3
//                duty0..3    requested duty for red, green, blue, white
//                d0..d3      registered PWM outputs for red, green, blue, white
//                period_end  one-cycle pulse after the counter wraps
//                upd_ack     one-cycle pulse when pending duties are applied
//                pend        captured duties are waiting for the boundary
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rgbw_pwm_gen #(
    parameter int PRESC   = 1,   // clk cycles per counter tick, 1..255
    parameter int STAGGER = 1    // 1: per-channel phase offset, 0: in phase
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       duty_ld,
    input  logic [7:0] duty0,
    input  logic [7:0] duty1,
    input  logic [7:0] duty2,
    input  logic [7:0] duty3,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       period_end,
    output logic       upd_ack,
    output logic       pend
);

    localparam logic [7:0] C_PRESC_LAST = 8'(PRESC - 1);
    localparam logic [7:0] C_CNT_LAST   = 8'hFF;

    logic [7:0]      r_presc;
    logic [7:0]      r_cnt;
    logic [3:0][7:0] r_pending;
    logic [3:0][7:0] r_active;
    logic            r_pend;
    logic            r_period_end;
    logic            r_upd_ack;
    logic [3:0]      r_d;

    logic            w_tick;
    logic            w_boundary;
    logic [3:0][7:0] w_duty_in;
    logic [3:0][7:0] w_phase;
    logic [3:0]      w_cmp;

    assign w_duty_in  = {duty3, duty2, duty1, duty0};

    // The prescaler restarts from 0 after reset, so the first tick lands
    // PRESC cycles after release and cnt holds 0 for that whole span.
    assign w_tick     = (r_presc == C_PRESC_LAST);
    assign w_boundary = w_tick && (r_cnt == C_CNT_LAST);

    // Per-channel phase and compare. Offsets wrap naturally in 8 bits.
    for (genvar k = 0; k < 4; k++) begin : g_ch
        localparam logic [7:0] C_OFS = (STAGGER != 0) ? 8'(64 * k) : 8'd0;
        assign w_phase[k] = r_cnt + C_OFS;
        assign w_cmp[k]   = (w_phase[k] < r_active[k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc      <= 8'd0;
            r_cnt        <= 8'd0;
            r_pending    <= '0;
            r_active     <= '0;
            r_pend       <= 1'b0;
            r_period_end <= 1'b0;
            r_upd_ack    <= 1'b0;
            r_d          <= 4'd0;
        end else begin
            r_presc <= w_tick ? 8'd0 : (r_presc + 8'd1);
            if (w_tick) begin
                r_cnt <= r_cnt + 8'd1;
            end

            r_period_end <= w_boundary;
            r_upd_ack    <= w_boundary && r_pend;

            // Active duties change only here, so a period always runs with
            // one consistent set of compare values.
            if (w_boundary && r_pend) begin
                r_active <= r_pending;
            end

            // A load coinciding with the boundary still sees the old pending
            // contents go to active above; the new values wait one more
            // period, so pend stays set in that case.
            if (duty_ld) begin
                r_pending <= w_duty_in;
                r_pend    <= 1'b1;
            end else if (w_boundary) begin
                r_pend    <= 1'b0;
            end

            // cnt and active only move on ticks, so the outputs hold between
            // ticks even though the compare is registered every cycle.
            r_d <= w_cmp;
        end
    end

    assign d0         = r_d[0];
    assign d1         = r_d[1];
    assign d2         = r_d[2];
    assign d3         = r_d[3];
    assign period_end = r_period_end;
    assign upd_ack    = r_upd_ack;
    assign pend       = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_rgbw_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgbw_pwm_gen
//  Description : Self-checking bench for rgbw_pwm_gen. Instance A
//                (PRESC=1, STAGGER=1) is driven through duty loads, a load
//                on the boundary cycle and a mid-period reset; expected
//                per-period results are queued as stimulus is issued and
//                checked at each period_end. Instance C (PRESC=3, STAGGER=0)
//                checks prescaled period length and in-phase channels.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rgbw_pwm_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------ A --
    logic       a_reset = 1'b1;
    logic       a_ld    = 1'b0;
    logic [7:0] a_du [4];
    wire  [3:0] a_d;
    wire        a_pe, a_ack, a_pend;

    rgbw_pwm_gen #(.PRESC(1), .STAGGER(1)) dut_a (
        .clk(clk), .reset(a_reset), .duty_ld(a_ld),
        .duty0(a_du[0]), .duty1(a_du[1]), .duty2(a_du[2]), .duty3(a_du[3]),
        .d0(a_d[0]), .d1(a_d[1]), .d2(a_d[2]), .d3(a_d[3]),
        .period_end(a_pe), .upd_ack(a_ack), .pend(a_pend)
    );

    typedef struct packed {
        logic [3:0][8:0] hi;
        logic [1:0]      ack;
        logic            pend;
        logic            rise_chk;
        logic [3:0][8:0] rise;
    } exp_t;

    exp_t a_q [$];

    function automatic exp_t mk_exp(input int h0, input int h1, input int h2, input int h3,
                                    input int ack, input logic pnd, input logic rchk);
        exp_t e;
        e.hi[0] = 9'(h0); e.hi[1] = 9'(h1); e.hi[2] = 9'(h2); e.hi[3] = 9'(h3);
        e.ack = 2'(ack);
        e.pend = pnd;
        e.rise_chk = rchk;
        // Staggered rise points for duty 64: d_k rises at cnt = 256-64k mod 256.
        e.rise[0] = 9'd0; e.rise[1] = 9'd192; e.rise[2] = 9'd128; e.rise[3] = 9'd64;
        return e;
    endfunction

    int         a_hi [4];
    int         a_rise [4];
    int         a_ackn, a_pos, a_cyc, a_win;
    logic [3:0] a_prev;
    bit         a_first;

    initial begin
        a_win = 0;
        forever begin
            @(negedge clk);
            if (a_reset) begin
                for (int k = 0; k < 4; k++) begin a_hi[k] = 0; a_rise[k] = -1; end
                a_ackn = 0; a_pos = 0; a_cyc = 0; a_prev = 4'd0; a_first = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (a_d[k]) a_hi[k]++;
                    if (a_d[k] && !a_prev[k]) a_rise[k] = a_pos;
                end
                a_prev = a_d;
                if (a_ack) a_ackn++;
                if (a_pe) begin
                    exp_t e;
                    if (a_first) begin
                        check_val("a_first_pe_cycle", a_cyc, 256);
                        a_first = 1'b0;
                    end
                    check_val("a_sb_nonempty", 32'(a_q.size() > 0), 1);
                    if (a_q.size() > 0) begin
                        e = a_q.pop_front();
                        for (int k = 0; k < 4; k++)
                            check_val($sformatf("a_w%0d_hi%0d", a_win, k), a_hi[k], 32'(e.hi[k]));
                        check_val($sformatf("a_w%0d_ack", a_win), a_ackn, 32'(e.ack));
                        check_val($sformatf("a_w%0d_pend", a_win), 32'(a_pend), 32'(e.pend));
                        if (e.rise_chk) begin
                            for (int k = 0; k < 4; k++)
                                check_val($sformatf("a_w%0d_rise%0d", a_win, k), a_rise[k], 32'(e.rise[k]));
                        end
                    end
                    a_win++;
                    for (int k = 0; k < 4; k++) begin a_hi[k] = 0; a_rise[k] = -1; end
                    a_ackn = 0;
                    a_pos  = 0;
                end else begin
                    a_pos++;
                end
                a_cyc++;
            end
        end
    end

    int a_cur = 0;

    task automatic a_adv(input int c);
        while (a_cur < c) begin
            @(posedge clk); #1;
            a_cur++;
        end
    endtask

    task automatic a_load(input int c, input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
        a_adv(c);
        a_ld = 1'b1;
        a_du[0] = v0; a_du[1] = v1; a_du[2] = v2; a_du[3] = v3;
        a_adv(c + 1);
        a_ld = 1'b0;
    endtask

    task automatic check_a_zero(input string pfx);
        check_val({pfx, "_d"},    32'(a_d),    0);
        check_val({pfx, "_pe"},   32'(a_pe),   0);
        check_val({pfx, "_ack"},  32'(a_ack),  0);
        check_val({pfx, "_pend"}, 32'(a_pend), 0);
    endtask

    task automatic stim_a();
        for (int k = 0; k < 4; k++) a_du[k] = 8'd0;
        a_reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_a_zero("a_rst");
        @(posedge clk); #1;
        a_reset = 1'b0;
        a_cur   = 0;

        // Period 0: all-zero output, load 64/128/192/255 for period 1.
        a_q.push_back(mk_exp(0, 0, 0, 0, 1, 1'b0, 1'b0));
        a_load(10, 8'd64, 8'd128, 8'd192, 8'd255);
        // Period 1: mixed duties; load 64 everywhere for the stagger check.
        a_q.push_back(mk_exp(64, 128, 192, 255, 1, 1'b0, 1'b0));
        a_load(286, 8'd64, 8'd64, 8'd64, 8'd64);
        // Period 2: two loads, the later one wins, active holds at 64.
        a_q.push_back(mk_exp(64, 64, 64, 64, 1, 1'b0, 1'b1));
        a_load(532, 8'd10, 8'd10, 8'd10, 8'd10);
        a_load(612, 8'd200, 8'd200, 8'd200, 8'd200);
        a_adv(662);
        @(negedge clk);
        check_val("a_pend_mid_period", 32'(a_pend), 1);
        // Period 3: pending 30, then 50 loaded exactly on the boundary cycle.
        a_q.push_back(mk_exp(200, 200, 200, 200, 1, 1'b1, 1'b0));
        a_load(808, 8'd30, 8'd30, 8'd30, 8'd30);
        a_load(1023, 8'd50, 8'd50, 8'd50, 8'd50);
        // Period 4 runs 30 while 50 stays pending.
        a_q.push_back(mk_exp(30, 30, 30, 30, 1, 1'b0, 1'b0));
        a_adv(1152);
        @(negedge clk);
        check_val("a_pend_after_bnd_ld", 32'(a_pend), 1);
        // Period 5: capture 77, then reset at cnt=130 with a load alongside.
        a_load(1300, 8'd77, 8'd77, 8'd77, 8'd77);
        a_adv(1410);
        a_reset = 1'b1;
        a_ld    = 1'b1;
        for (int k = 0; k < 4; k++) a_du[k] = 8'd99;
        a_adv(1411);
        a_ld = 1'b0;
        @(negedge clk);
        check_a_zero("a_midrst");
        a_adv(1412);
        a_reset = 1'b0;
        a_cur   = 0;

        // After release nothing is pending: two dark periods, then 90.
        a_q.push_back(mk_exp(0, 0, 0, 0, 0, 1'b0, 1'b0));
        a_q.push_back(mk_exp(0, 0, 0, 0, 1, 1'b0, 1'b0));
        a_q.push_back(mk_exp(90, 90, 90, 90, 0, 1'b0, 1'b0));
        a_load(261, 8'd90, 8'd90, 8'd90, 8'd90);
        a_adv(773);
    endtask

    // ------------------------------------------------------------------ C --
    logic       c_reset = 1'b1;
    logic       c_ld    = 1'b0;
    logic [7:0] c_du [4];
    wire  [3:0] c_d;
    wire        c_pe, c_ack, c_pend;

    rgbw_pwm_gen #(.PRESC(3), .STAGGER(0)) dut_c (
        .clk(clk), .reset(c_reset), .duty_ld(c_ld),
        .duty0(c_du[0]), .duty1(c_du[1]), .duty2(c_du[2]), .duty3(c_du[3]),
        .d0(c_d[0]), .d1(c_d[1]), .d2(c_d[2]), .d3(c_d[3]),
        .period_end(c_pe), .upd_ack(c_ack), .pend(c_pend)
    );

    int         c_hi [4];
    int         c_rise [4];
    int         c_pos, c_cyc, c_pe_n, c_last_pe;
    logic [3:0] c_prev;

    initial begin
        forever begin
            @(negedge clk);
            if (c_reset) begin
                for (int k = 0; k < 4; k++) begin c_hi[k] = 0; c_rise[k] = -1; end
                c_pos = 0; c_cyc = 0; c_pe_n = 0; c_last_pe = 0; c_prev = 4'd0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (c_d[k]) c_hi[k]++;
                    if (c_d[k] && !c_prev[k]) c_rise[k] = c_pos;
                end
                c_prev = c_d;
                if (c_pe) begin
                    if (c_pe_n == 0) begin
                        check_val("c_first_pe_cycle", c_cyc, 768);
                    end else begin
                        check_val($sformatf("c_pe%0d_spacing", c_pe_n), c_cyc - c_last_pe, 768);
                        for (int k = 0; k < 4; k++) begin
                            check_val($sformatf("c_pe%0d_hi%0d", c_pe_n, k), c_hi[k], 3);
                            check_val($sformatf("c_pe%0d_rise%0d", c_pe_n, k), c_rise[k], 0);
                        end
                    end
                    c_last_pe = c_cyc;
                    c_pe_n++;
                    for (int k = 0; k < 4; k++) begin c_hi[k] = 0; c_rise[k] = -1; end
                    c_pos = 0;
                end else begin
                    c_pos++;
                end
                c_cyc++;
            end
        end
    end

    int c_cur = 0;

    task automatic c_adv(input int c);
        while (c_cur < c) begin
            @(posedge clk); #1;
            c_cur++;
        end
    endtask

    task automatic stim_c();
        for (int k = 0; k < 4; k++) c_du[k] = 8'd0;
        c_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        c_reset = 1'b0;
        c_cur   = 0;
        c_adv(5);
        c_ld = 1'b1;
        for (int k = 0; k < 4; k++) c_du[k] = 8'd1;
        c_adv(6);
        c_ld = 1'b0;
        c_adv(2309);
    endtask

    // ------------------------------------------------------------- control --
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            stim_a();
            stim_c();
        join
        check_val("a_windows_seen", a_win, 8);
        check_val("a_sb_leftover", a_q.size(), 0);
        check_val("c_pe_count", c_pe_n, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
